usb_dfu_flash_sequencer: RTL and testbench

- Sits between the DFU class logic and the SPI flash bridge.
- Turns one DFU DNLOAD or UPLOAD block into a sequence of page-sized bridge transactions: drives the bridge page address and holds rd_request / wr_request for exactly the right number of bytes.
- Waits for the bridge to finish each erase, program or read before moving on, and reports busy/done/error back to the DFU state machine.

---
 rtl/usb_dfu_flash_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_usb_dfu_flash_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_dfu_flash_sequencer.sv
// usb_dfu_flash_sequencer
// Splits one DFU DNLOAD/UPLOAD block into page-sized SPI flash bridge
// transactions, waits for the bridge to finish each page, and reports
// busy/done/error back to the DFU class state machine.
module usb_dfu_flash_sequencer #(
   parameter int          PAGE_SIZE     = 256,
   parameter int          XFER_PAGES    = 1,
   parameter logic [15:0] BASE_PAGE     = 16'h0200,
   parameter logic [15:0] LIMIT_PAGE    = 16'h0FFF,
   parameter int          RD_EOF_CYCLES = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dn_start,
   input  logic        up_start,
   input  logic        abort,
   input  logic [15:0] dn_block,
   input  logic [15:0] dn_length,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] address,
   output logic        rd_request,
   output logic        wr_request,
   input  logic        wr_busy,
   input  logic        wr_data_get,
   input  logic        rd_data_put
);

   localparam int CNT_W = $clog2(PAGE_SIZE + 1);
   localparam int GAP_W = $clog2(RD_EOF_CYCLES + 2);
   localparam logic [CNT_W-1:0] PAGE_FULL = CNT_W'(PAGE_SIZE);
   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(RD_EOF_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_W_REQ,
      S_W_WAIT,
      S_R_REQ,
      S_R_GAP,
      S_ABORT_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [15:0]      address_q, address_d;
   logic             rd_req_q, rd_req_d;
   logic             wr_req_q, wr_req_d;
   logic [CNT_W-1:0] bytecnt_q, bytecnt_d;
   logic [15:0]      remaining_q, remaining_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             seen_busy_q, seen_busy_d;
   logic             abort_lo_q, abort_lo_d;
   logic             aborted_q, aborted_d;
   logic             is_read_q, is_read_d;
   logic [31:0]      page_q, page_d;

   logic [31:0]      start_page;
   logic [31:0]      pages_needed;
   logic             range_bad;
   logic [CNT_W-1:0] cnt_inc;
   logic [15:0]      rem_dec;
   logic             page_end;

   // Start page and partition bound, both in 32 bits so large block numbers cannot wrap into range
   always_comb begin
      start_page   = 32'(BASE_PAGE) + 32'(dn_block) * 32'(XFER_PAGES);
      pages_needed = (32'(remaining_q) + 32'(PAGE_SIZE - 1)) / 32'(PAGE_SIZE);
      range_bad    = (page_q + pages_needed) > (32'(LIMIT_PAGE) + 32'd1);
      cnt_inc      = bytecnt_q + CNT_W'(1);
      rem_dec      = remaining_q - 16'd1;
      page_end     = (cnt_inc == PAGE_FULL) || (rem_dec == 16'd0);
   end

   // Next-state and next-output logic for the sequencer
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      address_d   = address_q;
      rd_req_d    = rd_req_q;
      wr_req_d    = wr_req_q;
      bytecnt_d   = bytecnt_q;
      remaining_d = remaining_q;
      gap_d       = gap_q;
      seen_busy_d = seen_busy_q;
      abort_lo_d  = abort_lo_q;
      aborted_d   = aborted_q;
      is_read_d   = is_read_q;
      page_d      = page_q;
      unique case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (dn_start || up_start) begin
               state_d     = S_CHECK;
               busy_d      = 1'b1;
               is_read_d   = !dn_start;
               page_d      = start_page;
               remaining_d = dn_length;
               aborted_d   = 1'b0;
            end
         end
         S_CHECK: begin
            if (range_bad) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else if (remaining_q == 16'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               address_d = page_q[15:0];
               bytecnt_d = '0;
               if (is_read_q) begin
                  rd_req_d = 1'b1;
                  state_d  = S_R_REQ;
               end else begin
                  wr_req_d = 1'b1;
                  state_d  = S_W_REQ;
               end
            end
         end
         S_W_REQ: begin
            if (abort) begin
               wr_req_d   = 1'b0;
               abort_lo_d = 1'b0;
               state_d    = S_ABORT_WAIT;
            end else if (wr_data_get) begin
               bytecnt_d   = cnt_inc;
               remaining_d = rem_dec;
               if (page_end) begin
                  wr_req_d    = 1'b0;
                  seen_busy_d = 1'b0;
                  state_d     = S_W_WAIT;
               end
            end
         end
         S_W_WAIT: begin
            if (abort) begin
               abort_lo_d = 1'b0;
               state_d    = S_ABORT_WAIT;
            end else if (seen_busy_q && !wr_busy) begin
               if (remaining_q != 16'd0) begin
                  address_d = address_q + 16'd1;
                  bytecnt_d = '0;
                  wr_req_d  = 1'b1;
                  state_d   = S_W_REQ;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (wr_busy) begin
               seen_busy_d = 1'b1;
            end
         end
         S_ABORT_WAIT: begin
            if (wr_busy) begin
               abort_lo_d = 1'b0;
            end else if (abort_lo_q) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               abort_lo_d = 1'b1;
            end
         end
         S_R_REQ: begin
            if (abort) begin
               rd_req_d  = 1'b0;
               gap_d     = GAP_LOAD;
               aborted_d = 1'b1;
               state_d   = S_R_GAP;
            end else if (rd_data_put) begin
               bytecnt_d   = cnt_inc;
               remaining_d = rem_dec;
               if (page_end) begin
                  rd_req_d = 1'b0;
                  gap_d    = GAP_LOAD;
                  state_d  = S_R_GAP;
               end
            end
         end
         S_R_GAP: begin
            if (abort) begin
               gap_d     = GAP_LOAD;
               aborted_d = 1'b1;
            end else if (gap_q <= GAP_W'(1)) begin
               if (aborted_q) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else if (remaining_q != 16'd0) begin
                  address_d = address_q + 16'd1;
                  bytecnt_d = '0;
                  rd_req_d  = 1'b1;
                  state_d   = S_R_REQ;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset drops both requests on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         address_q   <= 16'd0;
         rd_req_q    <= 1'b0;
         wr_req_q    <= 1'b0;
         bytecnt_q   <= '0;
         remaining_q <= 16'd0;
         gap_q       <= '0;
         seen_busy_q <= 1'b0;
         abort_lo_q  <= 1'b0;
         aborted_q   <= 1'b0;
         is_read_q   <= 1'b0;
         page_q      <= 32'd0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         address_q   <= address_d;
         rd_req_q    <= rd_req_d;
         wr_req_q    <= wr_req_d;
         bytecnt_q   <= bytecnt_d;
         remaining_q <= remaining_d;
         gap_q       <= gap_d;
         seen_busy_q <= seen_busy_d;
         abort_lo_q  <= abort_lo_d;
         aborted_q   <= aborted_d;
         is_read_q   <= is_read_d;
         page_q      <= page_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign address    = address_q;
   assign rd_request = rd_req_q;
   assign wr_request = wr_req_q;

endmodule

// File: tb/tb_usb_dfu_flash_sequencer.sv
// tb_usb_dfu_flash_sequencer
// Drives the sequencer with directed and randomized DFU blocks against a
// small bridge model, and compares every cycle with a transaction-level model.
module tb_usb_dfu_flash_sequencer;

   localparam int          PS    = 256;
   localparam int          XP    = 2;
   localparam logic [15:0] BASE  = 16'h0200;
   localparam logic [15:0] LIMIT = 16'h0FFF;
   localparam int          RDGAP = 24;
   localparam int          GAP_ACT = (RDGAP < 1) ? 1 : RDGAP;

   localparam int M_IDLE = 0, M_CHECK = 1, M_WX = 2, M_WSETTLE = 3,
                  M_ABORT = 4, M_RX = 5, M_RGAP = 6;

   logic        clk, reset, dn_start, up_start, abort;
   logic [15:0] dn_block, dn_length;
   logic        busy, done, error, rd_request, wr_request;
   logic [15:0] address;
   logic        wr_busy, wr_data_get, rd_data_put;

   usb_dfu_flash_sequencer #(
      .PAGE_SIZE(PS), .XFER_PAGES(XP), .BASE_PAGE(BASE),
      .LIMIT_PAGE(LIMIT), .RD_EOF_CYCLES(RDGAP)
   ) dut (
      .clk(clk), .reset(reset), .dn_start(dn_start), .up_start(up_start),
      .abort(abort), .dn_block(dn_block), .dn_length(dn_length),
      .busy(busy), .done(done), .error(error), .address(address),
      .rd_request(rd_request), .wr_request(wr_request), .wr_busy(wr_busy),
      .wr_data_get(wr_data_get), .rd_data_put(rd_data_put)
   );

   int checks = 0;
   int fails  = 0;

   // stimulus requests consumed by the next cycle
   bit          reqDn, reqUp, reqAbort, reqReset;
   logic [15:0] reqBlock, reqLen;

   // bridge behaviour knobs
   int busyLen  = 0;
   int getRate  = 70;
   bit spurious = 0;
   int busyLeft = 0;
   bit prevWr   = 0;

   // reference model: expected outputs for the coming cycle
   bit          eBusy, eDone, eErr, eWr, eRd;
   logic [15:0] eAddr;
   int          mMode = M_IDLE;
   bit          mRead, mSawBusy, mAborted;
   longint      mPage0;
   int          mLen, mLeftPage, mPageIdx, mGap, mLow;
   int          pageQ[$];
   bit          checkEn = 0;

   // scoreboard of what the bridge saw
   logic [15:0] pgAddr[$];
   int          pgBytes[$];
   int          gapRuns[$];
   int          doneCnt, errCnt, gapRun;
   bit          prevAny, prevRd, gapCounting;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs with the model's expectation for this cycle
   task automatic checkOutput();
      check("busy", 32'(busy), 32'(eBusy));
      check("done", 32'(done), 32'(eDone));
      check("error", 32'(error), 32'(eErr));
      check("wr_request", 32'(wr_request), 32'(eWr));
      check("rd_request", 32'(rd_request), 32'(eRd));
      check("address", 32'(address), 32'(eAddr));
      check("req_exclusive", 32'(wr_request & rd_request), 32'd0);
   endtask

   // Drive requested control inputs plus the bridge responses for this cycle
   task automatic applyStimulus();
      reset     = reqReset;
      dn_start  = reqDn;
      up_start  = reqUp;
      abort     = reqAbort;
      dn_block  = reqBlock;
      dn_length = reqLen;
      reqReset = 0; reqDn = 0; reqUp = 0; reqAbort = 0;
      wr_data_get = wr_request ? ($urandom_range(99) < getRate)
                               : (spurious && $urandom_range(7) == 0);
      rd_data_put = rd_request ? ($urandom_range(99) < getRate)
                               : (spurious && $urandom_range(7) == 0);
      if (prevWr && !wr_request)
         busyLeft = (busyLen > 0) ? busyLen : int'($urandom_range(8, 2));
      wr_busy = (busyLeft > 0);
      if (busyLeft > 0) busyLeft--;
      prevWr = wr_request;
   endtask

   task automatic openPage();
      mLeftPage = pageQ.pop_front();
      eAddr = 16'(mPage0 + longint'(mPageIdx));
      mPageIdx++;
      if (mRead) begin eRd = 1; mMode = M_RX; end
      else       begin eWr = 1; mMode = M_WX; end
   endtask

   // Advance the reference model using the inputs driven this cycle
   task automatic modelAdvance();
      longint lastPage;
      eDone = 0;
      eErr  = 0;
      if (reset) begin
         mMode = M_IDLE; eBusy = 0; eWr = 0; eRd = 0; eAddr = 16'h0000;
         pageQ.delete();
         return;
      end
      case (mMode)
         M_IDLE: begin
            if (dn_start || up_start) begin
               mMode = M_CHECK; eBusy = 1; mRead = !dn_start; mAborted = 0;
               mPage0 = longint'(BASE) + longint'(dn_block) * XP;
               mLen = int'(dn_length); mPageIdx = 0;
               pageQ.delete();
               for (int left = mLen; left > 0; left -= PS)
                  pageQ.push_back((left > PS) ? PS : left);
            end else eBusy = 0;
         end
         M_CHECK: begin
            lastPage = mPage0 + longint'((mLen + PS - 1) / PS) - 1;
            if (lastPage > longint'(LIMIT)) begin eErr = 1; mMode = M_IDLE; end
            else if (mLen == 0) begin eDone = 1; mMode = M_IDLE; end
            else openPage();
         end
         M_WX: begin
            if (abort) begin eWr = 0; mLow = 0; mMode = M_ABORT; end
            else if (wr_data_get) begin
               mLeftPage--;
               if (mLeftPage == 0) begin eWr = 0; mSawBusy = 0; mMode = M_WSETTLE; end
            end
         end
         M_WSETTLE: begin
            if (abort) begin mLow = 0; mMode = M_ABORT; end
            else if (mSawBusy && !wr_busy) begin
               if (pageQ.size() > 0) openPage();
               else begin eDone = 1; mMode = M_IDLE; end
            end else if (wr_busy) mSawBusy = 1;
         end
         M_ABORT: begin
            if (wr_busy) mLow = 0;
            else begin
               mLow++;
               if (mLow == 2) begin eBusy = 0; mMode = M_IDLE; end
            end
         end
         M_RX: begin
            if (abort) begin eRd = 0; mGap = 0; mAborted = 1; mMode = M_RGAP; end
            else if (rd_data_put) begin
               mLeftPage--;
               if (mLeftPage == 0) begin eRd = 0; mGap = 0; mMode = M_RGAP; end
            end
         end
         M_RGAP: begin
            if (abort) begin mGap = 0; mAborted = 1; end
            else begin
               mGap++;
               if (mGap >= GAP_ACT) begin
                  if (mAborted) begin eBusy = 0; mMode = M_IDLE; end
                  else if (pageQ.size() > 0) openPage();
                  else begin eDone = 1; mMode = M_IDLE; end
               end
            end
         end
         default: mMode = M_IDLE;
      endcase
   endtask

   // Record per-page byte counts, pulses and read gap lengths as the bridge sees them
   task automatic scoreboard();
      bit any;
      any = wr_request || rd_request;
      if (any && !prevAny) begin pgAddr.push_back(address); pgBytes.push_back(0); end
      if (((wr_request && wr_data_get) || (rd_request && rd_data_put)) && !abort && pgBytes.size() > 0)
         pgBytes[pgBytes.size()-1] = pgBytes[pgBytes.size()-1] + 1;
      if (done)  doneCnt++;
      if (error) errCnt++;
      if (rd_request) begin
         if (gapCounting) gapRuns.push_back(gapRun);
         gapCounting = 0;
      end else if (prevRd) begin
         gapCounting = 1; gapRun = 1;
      end else if (gapCounting) begin
         if (done || !busy) begin gapRuns.push_back(gapRun); gapCounting = 0; end
         else gapRun++;
      end
      prevAny = any;
      prevRd  = rd_request;
   endtask

   task automatic step();
      @(negedge clk);
      if (checkEn) checkOutput();
      applyStimulus();
      scoreboard();
      modelAdvance();
   endtask

   task automatic clearScore();
      pgAddr.delete(); pgBytes.delete(); gapRuns.delete();
      doneCnt = 0; errCnt = 0; gapCounting = 0;
   endtask

   function automatic logic [15:0] randBlock();
      if ($urandom_range(9) < 8) return 16'($urandom_range(16'h06FF));
      return 16'($urandom_range(16'hFFFF, 16'h0700));
   endfunction

   task automatic runUntilIdle(input int budget, input bit poke);
      int n = 0;
      do begin
         if (poke && busy) begin
            if ($urandom_range(299) == 0) reqAbort = 1;
            if ($urandom_range(199) == 0) begin
               reqDn = 1; reqBlock = randBlock(); reqLen = 16'($urandom_range(XP*PS));
            end
         end
         step();
         n++;
      end while ((busy || n < 3) && n < budget);
      check("idle_within_budget", 32'(busy), 32'd0);
   endtask

   task automatic startXfer(input bit up, input logic [15:0] blk, input logic [15:0] len);
      clearScore();
      reqDn = !up; reqUp = up; reqBlock = blk; reqLen = len;
      step();
      runUntilIdle(3000, 0);
   endtask

   initial begin
      int n;
      reset = 1; dn_start = 0; up_start = 0; abort = 0; dn_block = 0; dn_length = 0;
      wr_busy = 0; wr_data_get = 0; rd_data_put = 0;
      reqReset = 1; reqBlock = 0; reqLen = 0;
      step();
      checkEn = 1;
      reqReset = 1;
      step();
      step();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_address", 32'(address), 32'd0);
      check("reset_requests", 32'({rd_request, wr_request}), 32'd0);

      $display("[TB] single page download, long bridge busy");
      busyLen = 50;
      startXfer(0, 16'd0, 16'd256);
      check("t1_pages", 32'(pgAddr.size()), 32'd1);
      check("t1_address", 32'(pgAddr[0]), 32'h0200);
      check("t1_bytes", 32'(pgBytes[0]), 32'd256);
      check("t1_done", 32'(doneCnt), 32'd1);

      $display("[TB] two page download");
      busyLen = 0;
      startXfer(0, 16'd3, 16'd300);
      check("t2_pages", 32'(pgAddr.size()), 32'd2);
      check("t2_addr0", 32'(pgAddr[0]), 32'h0206);
      check("t2_bytes0", 32'(pgBytes[0]), 32'd256);
      check("t2_addr1", 32'(pgAddr[1]), 32'h0207);
      check("t2_bytes1", 32'(pgBytes[1]), 32'd44);
      check("t2_done", 32'(doneCnt), 32'd1);

      $display("[TB] upload with trailing bytes in the gap");
      spurious = 1;
      startXfer(1, 16'd1, 16'd100);
      spurious = 0;
      check("t3_address", 32'(pgAddr[0]), 32'h0202);
      check("t3_bytes", 32'(pgBytes[0]), 32'd100);
      check("t3_gap", 32'(gapRuns[0]), 32'd24);
      check("t3_done", 32'(doneCnt), 32'd1);

      $display("[TB] out of range and zero length");
      startXfer(0, 16'h0E00, 16'd16);
      check("t4_error", 32'(errCnt), 32'd1);
      check("t4_no_done", 32'(doneCnt), 32'd0);
      check("t4_no_req", 32'(pgAddr.size()), 32'd0);
      startXfer(0, 16'd5, 16'd0);
      check("t4z_done", 32'(doneCnt), 32'd1);
      check("t4z_no_req", 32'(pgAddr.size()), 32'd0);

      $display("[TB] abort after ten bytes");
      clearScore();
      busyLen = 6;
      reqDn = 1; reqBlock = 16'd4; reqLen = 16'd200;
      n = 0;
      do begin step(); n++; end while ((pgBytes.size() == 0 || pgBytes[0] < 10) && n < 2000);
      reqAbort = 1;
      step();
      reqDn = 1; reqBlock = 16'd0; reqLen = 16'd16;
      step();
      runUntilIdle(3000, 0);
      check("t5_bytes", 32'(pgBytes[0]), 32'd10);
      check("t5_pages", 32'(pgAddr.size()), 32'd1);
      check("t5_no_done", 32'(doneCnt), 32'd0);

      $display("[TB] simultaneous starts then reset mid-write");
      busyLen = 0;
      clearScore();
      reqDn = 1; reqUp = 1; reqBlock = 16'd2; reqLen = 16'd200;
      n = 0;
      do begin step(); n++; end while (!(wr_request || rd_request) && n < 20);
      check("t6_write_path", 32'({rd_request, wr_request}), 32'd1);
      repeat (5) step();
      reqReset = 1;
      step();
      step();
      check("t6_reset_outputs", 32'({busy, done, error, rd_request, wr_request}), 32'd0);
      check("t6_reset_address", 32'(address), 32'd0);
      repeat (15) step();

      $display("[TB] randomized blocks");
      for (int t = 0; t < 25; t++) begin
         getRate  = int'($urandom_range(100, 30));
         spurious = ($urandom_range(1) == 1);
         clearScore();
         reqDn = ($urandom_range(1) == 1);
         reqUp = !reqDn || ($urandom_range(3) == 0);
         reqBlock = randBlock();
         reqLen = 16'($urandom_range(XP*PS));
         step();
         runUntilIdle(5000, 1);
         repeat (12) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
